// File: rtl/cpu_run_controller.sv
// Multi-cycle run controller: sequences FETCH/DECODE/EXECUTE, gates datapath
// commit strobes, and adds pause/step/resume, PC breakpoint and busy stall.
module cpu_run_controller #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned CNT_W   = 32,
  parameter logic [5:0]  HALT_OP = 6'b100100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_req,
  input  logic             resume_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic [5:0]       opcode,
  input  logic             ex_busy,
  input  logic             updPc_in,
  input  logic             wr_reg_in,
  input  logic             wrMem_in,
  output logic             updPc_g,
  output logic             wr_reg_g,
  output logic             wrMem_g,
  output logic [2:0]       state,
  output logic             paused,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    FETCH   = 3'b000,
    DECODE  = 3'b001,
    EXECUTE = 3'b010,
    PAUSE   = 3'b011,
    HALT    = 3'b100
  } state_t;

  state_t st;
  logic   step_pending;
  logic   bp_skip;
  logic   commit;
  logic   bp_hit;
  logic   active;

  assign commit = (st == EXECUTE) && !ex_busy;
  assign bp_hit = bp_en && (pc == bp_addr) && !bp_skip;
  assign active = (st == FETCH) || (st == DECODE) || (st == EXECUTE);

  assign updPc_g  = updPc_in  & commit;
  assign wr_reg_g = wr_reg_in & commit;
  assign wrMem_g  = wrMem_in  & commit;

  assign state  = st;
  assign paused = (st == PAUSE);
  assign halted = (st == HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= PAUSE;
      step_pending <= 1'b0;
      bp_skip      <= 1'b0;
      instr_count  <= '0;
      cycle_count  <= '0;
    end else begin
      if (active)
        cycle_count <= cycle_count + CNT_W'(1);

      case (st)
        PAUSE: begin
          if (resume_req) begin
            st           <= FETCH;
            step_pending <= 1'b0;
            bp_skip      <= 1'b1;
          end else if (step_req) begin
            st           <= FETCH;
            step_pending <= 1'b1;
            bp_skip      <= 1'b1;
          end
        end
        FETCH:   st <= bp_hit ? PAUSE : DECODE;
        DECODE:  st <= EXECUTE;
        EXECUTE: begin
          if (!ex_busy) begin
            instr_count <= instr_count + CNT_W'(1);
            bp_skip     <= 1'b0;
            // Halt takes priority over a pending single-step return to PAUSE.
            if (opcode == HALT_OP) begin
              st <= HALT;
            end else if (step_pending) begin
              st           <= PAUSE;
              step_pending <= 1'b0;
            end else begin
              st <= FETCH;
            end
          end
        end
        HALT:    st <= HALT;
        default: st <= PAUSE;
      endcase
    end
  end

endmodule
